reg_ac: RTL and testbench

Accumulator stage of the basic computer datapath, directly downstream of the data register. It holds the 16-bit AC and the 1-bit carry flip-flop E. It executes the memory-reference AC operations (AND, ADD, LDA) on the data register output at T5. It also executes the register-reference instructions at T3, and drives the AC value, the skip request and the halt flag to the control unit and bus.

---
 rtl/reg_ac.sv | 85 ++++++++
 tb/tb_reg_ac.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_ac.sv
// reg_ac: accumulator AC and carry flip-flop E of the basic computer datapath
module reg_ac #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN_IR,
    input  logic [WIDTH-1:0] Q_DR,
    input  logic [2:0]       t,
    output logic [WIDTH-1:0] Q_AC,
    output logic             E,
    output logic             AC_ZERO,
    output logic             SKIP,
    output logic             HALT
);
    logic [WIDTH-1:0] ac_q, ac_d;
    logic             e_q, e_d;
    logic             halt_q, halt_d;
    logic [2:0]       op;
    logic             rr_t3;
    logic [12:0]      above;
    logic [11:0]      sel;

    assign op    = IN_IR[14:12];
    assign rr_t3 = (op == 3'd7) && !IN_IR[15] && (t == 3'd3);

    // Only the highest-order set bit of the register-reference field is acted on.
    assign above[12] = 1'b0;
    for (genvar k = 11; k >= 0; k--) begin : g_sel
        assign above[k] = above[k+1] | IN_IR[k];
        assign sel[k]   = IN_IR[k] & ~above[k+1];
    end

    // Next-state of AC, E and HALT; a set HALT freezes AC and E.
    always_comb begin
        ac_d   = ac_q;
        e_d    = e_q;
        halt_d = halt_q | (rr_t3 & sel[0]);
        if (!halt_q && t == 3'd5) begin
            if (op == 3'd0)
                ac_d = ac_q & Q_DR;
            else if (op == 3'd1)
                {e_d, ac_d} = {1'b0, ac_q} + {1'b0, Q_DR};
            else if (op == 3'd2)
                ac_d = Q_DR;
        end
        if (!halt_q && rr_t3) begin
            ac_d = sel[11] ? '0 :
                   sel[9]  ? ~ac_q :
                   sel[7]  ? {e_q, ac_q[WIDTH-1:1]} :
                   sel[6]  ? {ac_q[WIDTH-2:0], e_q} :
                   sel[5]  ? ac_q + {{(WIDTH-1){1'b0}}, 1'b1} : ac_q;
            e_d  = sel[10] ? 1'b0 :
                   sel[8]  ? ~e_q :
                   sel[7]  ? ac_q[0] :
                   sel[6]  ? ac_q[WIDTH-1] : e_q;
        end
    end

    // Skip request is evaluated on pre-edge state so the PC can use it at the T3 edge.
    always_comb begin
        SKIP = rr_t3 & ((sel[4] & ~ac_q[WIDTH-1]) |
                        (sel[3] &  ac_q[WIDTH-1]) |
                        (sel[2] & ~|ac_q) |
                        (sel[1] & ~e_q));
    end

    // State registers with synchronous reset taking priority over any operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ac_q   <= '0;
            e_q    <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            ac_q   <= ac_d;
            e_q    <= e_d;
            halt_q <= halt_d;
        end
    end

    assign Q_AC    = ac_q;
    assign E       = e_q;
    assign HALT    = halt_q;
    assign AC_ZERO = ~|ac_q;
endmodule

// File: tb/tb_reg_ac.sv
// tb_reg_ac: scoreboard-driven bench for the accumulator stage
module tb_reg_ac;
    logic        CLK, RST;
    logic [15:0] IN_IR, Q_DR, Q_AC;
    logic [2:0]  t;
    logic        E, AC_ZERO, SKIP, HALT;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        rst;
        logic [15:0] ir;
        logic [15:0] dr;
        logic [2:0]  tt;
        logic [15:0] ac;
        logic        e;
        logic        h;
    } st_t;

    typedef struct {
        logic [15:0] ac;
        logic        e;
        logic        h;
    } exp_t;

    exp_t exp_q[$];

    reg_ac #(.WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .IN_IR(IN_IR), .Q_DR(Q_DR), .t(t),
        .Q_AC(Q_AC), .E(E), .AC_ZERO(AC_ZERO), .SKIP(SKIP), .HALT(HALT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Drive one cycle of stimulus, record the expected post-edge state, sample away from the edge.
    task automatic apply(input st_t s);
        RST   = s.rst;
        IN_IR = s.ir;
        Q_DR  = s.dr;
        t     = s.tt;
        exp_q.push_back('{s.ac, s.e, s.h});
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        exp_t x;
        st_t v[2] = '{
            '{1'b1, 16'h1000, 16'hFFFF, 3'd5, 16'h0000, 1'b0, 1'b0},
            '{1'b1, 16'h1000, 16'hFFFF, 3'd5, 16'h0000, 1'b0, 1'b0}
        };
        foreach (v[k]) begin
            apply(v[k]);
            x = exp_q.pop_front();
            checks++;
            if ({Q_AC, E, HALT} !== {x.ac, x.e, x.h}) begin
                errors++;
                $display("FAIL reset[%0d] got ac=%h e=%b h=%b exp ac=%h e=%b h=%b", k, Q_AC, E, HALT, x.ac, x.e, x.h);
            end
        end
        checks++;
        if ({AC_ZERO, SKIP} !== 2'b10) begin
            errors++;
            $display("FAIL reset_flags got zero=%b skip=%b exp zero=1 skip=0", AC_ZERO, SKIP);
        end
    endtask

    task automatic test_lda_add;
        exp_t x;
        st_t v[2] = '{
            '{1'b0, 16'h2000, 16'h8001, 3'd5, 16'h8001, 1'b0, 1'b0},
            '{1'b0, 16'h1000, 16'h8000, 3'd5, 16'h0001, 1'b1, 1'b0}
        };
        foreach (v[k]) begin
            apply(v[k]);
            x = exp_q.pop_front();
            checks++;
            if ({Q_AC, E, HALT} !== {x.ac, x.e, x.h}) begin
                errors++;
                $display("FAIL lda_add[%0d] got ac=%h e=%b h=%b exp ac=%h e=%b h=%b", k, Q_AC, E, HALT, x.ac, x.e, x.h);
            end
        end
    endtask

    task automatic test_and_cma;
        exp_t x;
        st_t v[5] = '{
            '{1'b0, 16'h2000, 16'h1234, 3'd5, 16'h1234, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 16'h0FF0, 3'd5, 16'h0230, 1'b1, 1'b0},
            '{1'b0, 16'h7200, 16'h0000, 3'd3, 16'hFDCF, 1'b1, 1'b0},
            '{1'b0, 16'hF200, 16'h0000, 3'd3, 16'hFDCF, 1'b1, 1'b0},
            '{1'b0, 16'h3000, 16'h0000, 3'd5, 16'hFDCF, 1'b1, 1'b0}
        };
        foreach (v[k]) begin
            apply(v[k]);
            x = exp_q.pop_front();
            checks++;
            if ({Q_AC, E, HALT} !== {x.ac, x.e, x.h}) begin
                errors++;
                $display("FAIL and_cma[%0d] got ac=%h e=%b h=%b exp ac=%h e=%b h=%b", k, Q_AC, E, HALT, x.ac, x.e, x.h);
            end
        end
    endtask

    task automatic test_rotate_priority;
        exp_t x;
        st_t v[8] = '{
            '{1'b0, 16'h2000, 16'h8001, 3'd5, 16'h8001, 1'b1, 1'b0},
            '{1'b0, 16'h7400, 16'h0000, 3'd3, 16'h8001, 1'b0, 1'b0},
            '{1'b0, 16'h7040, 16'h0000, 3'd3, 16'h0002, 1'b1, 1'b0},
            '{1'b0, 16'h7080, 16'h0000, 3'd3, 16'h8001, 1'b0, 1'b0},
            '{1'b0, 16'h7100, 16'h0000, 3'd3, 16'h8001, 1'b1, 1'b0},
            '{1'b0, 16'h7C00, 16'h0000, 3'd3, 16'h0000, 1'b1, 1'b0},
            '{1'b0, 16'h7000, 16'h0000, 3'd3, 16'h0000, 1'b1, 1'b0},
            '{1'b0, 16'h2000, 16'h4321, 3'd4, 16'h0000, 1'b1, 1'b0}
        };
        foreach (v[k]) begin
            apply(v[k]);
            x = exp_q.pop_front();
            checks++;
            if ({Q_AC, E, HALT} !== {x.ac, x.e, x.h}) begin
                errors++;
                $display("FAIL rotate[%0d] got ac=%h e=%b h=%b exp ac=%h e=%b h=%b", k, Q_AC, E, HALT, x.ac, x.e, x.h);
            end
        end
    endtask

    task automatic test_inc_skip;
        exp_t x;
        st_t v[2] = '{
            '{1'b0, 16'h2000, 16'hFFFF, 3'd5, 16'hFFFF, 1'b1, 1'b0},
            '{1'b0, 16'h7020, 16'h0000, 3'd3, 16'h0000, 1'b1, 1'b0}
        };
        logic [15:0] sir[8] = '{16'h7004, 16'h7004, 16'h7010, 16'h7008, 16'h7002, 16'hF004, 16'h7006, 16'h7024};
        logic [2:0]  st[8]  = '{3'd3, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
        logic        sk[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        foreach (v[k]) begin
            apply(v[k]);
            x = exp_q.pop_front();
            checks++;
            if ({Q_AC, E, HALT} !== {x.ac, x.e, x.h}) begin
                errors++;
                $display("FAIL inc[%0d] got ac=%h e=%b h=%b exp ac=%h e=%b h=%b", k, Q_AC, E, HALT, x.ac, x.e, x.h);
            end
        end
        checks++;
        if (AC_ZERO !== 1'b1) begin
            errors++;
            $display("FAIL inc_zero got %b exp 1", AC_ZERO);
        end
        foreach (sir[k]) begin
            @(negedge CLK);
            IN_IR = sir[k];
            t     = st[k];
            #1;
            checks++;
            if (SKIP !== sk[k]) begin
                errors++;
                $display("FAIL skip[%0d] ir=%h t=%0d got %b exp %b", k, sir[k], st[k], SKIP, sk[k]);
            end
            t = 3'd0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_hlt;
        exp_t x;
        st_t v[4] = '{
            '{1'b0, 16'h7001, 16'h0000, 3'd3, 16'h0000, 1'b1, 1'b1},
            '{1'b0, 16'h2000, 16'h5555, 3'd5, 16'h0000, 1'b1, 1'b1},
            '{1'b0, 16'h7200, 16'h0000, 3'd3, 16'h0000, 1'b1, 1'b1},
            '{1'b1, 16'h2000, 16'h5555, 3'd5, 16'h0000, 1'b0, 1'b0}
        };
        foreach (v[k]) begin
            apply(v[k]);
            x = exp_q.pop_front();
            checks++;
            if ({Q_AC, E, HALT} !== {x.ac, x.e, x.h}) begin
                errors++;
                $display("FAIL hlt[%0d] got ac=%h e=%b h=%b exp ac=%h e=%b h=%b", k, Q_AC, E, HALT, x.ac, x.e, x.h);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t x;
        st_t v[5] = '{
            '{1'b0, 16'h1000, 16'h0001, 3'd5, 16'h0001, 1'b0, 1'b0},
            '{1'b0, 16'h1000, 16'h0001, 3'd5, 16'h0002, 1'b0, 1'b0},
            '{1'b0, 16'h1000, 16'h0001, 3'd5, 16'h0003, 1'b0, 1'b0},
            '{1'b0, 16'h1000, 16'hFFFF, 3'd5, 16'h0002, 1'b1, 1'b0},
            '{1'b0, 16'h1000, 16'hFFFF, 3'd4, 16'h0002, 1'b1, 1'b0}
        };
        foreach (v[k]) begin
            apply(v[k]);
            x = exp_q.pop_front();
            checks++;
            if ({Q_AC, E, HALT} !== {x.ac, x.e, x.h}) begin
                errors++;
                $display("FAIL b2b[%0d] got ac=%h e=%b h=%b exp ac=%h e=%b h=%b", k, Q_AC, E, HALT, x.ac, x.e, x.h);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size());
        end
    endtask

    initial begin
        RST   = 1'b1;
        IN_IR = 16'h0000;
        Q_DR  = 16'h0000;
        t     = 3'd0;
        @(negedge CLK);
        test_reset;
        test_lda_add;
        test_and_cma;
        test_rotate_priority;
        test_inc_skip;
        test_hlt;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
